// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the asynchronous instruction ROM and
// loads the IF/ID pipeline register with start-up, stall, flush, redirect and halt handling.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [31:0]           RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  ENABLE,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [31:0]           pc_if,
  output logic [31:0]           pc_id,
  output logic [DATA_WIDTH-1:0] instr_id,
  output logic                  valid_id,
  output logic                  halted,
  output logic                  misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                  state_q;
  // PC is kept word-aligned, so only bits [31:2] are stored
  logic [29:0]             pc_q;
  logic [31:0]             pc_id_q;
  logic [DATA_WIDTH-1:0]   instr_id_q;
  logic                    valid_id_q;
  logic                    halted_q;
  logic                    misalign_q;
  logic [29:0]             pc_inc_d;
  logic                    out_of_range_d;

  assign pc_inc_d       = pc_q + 30'd1;
  assign out_of_range_d = (pc_q[29:ADDR_WIDTH] != '0);

  assign imem_addr    = pc_q[ADDR_WIDTH-1:0];
  assign pc_if        = {pc_q, 2'b00};
  assign pc_id        = pc_id_q;
  assign instr_id     = instr_id_q;
  assign valid_id     = valid_id_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC[31:2];
      pc_id_q    <= 32'h0000_0000;
      instr_id_q <= NOP_INSTR;
      valid_id_q <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= ENABLE ? RUN : IDLE;
        end
        RUN: begin
          if (branch_taken) begin
            pc_q       <= branch_target[31:2];
            instr_id_q <= NOP_INSTR;
            valid_id_q <= 1'b0;
            misalign_q <= |branch_target[1:0];
          end else if (flush) begin
            instr_id_q <= NOP_INSTR;
            valid_id_q <= 1'b0;
            if (!stall && ENABLE) begin
              pc_q <= pc_inc_d;
            end else begin
              pc_q <= pc_q;
            end
          end else if (stall || !ENABLE) begin
            pc_q <= pc_q;
          end else if (out_of_range_d) begin
            // Fetch ran past the ROM end: park here until redirected
            state_q    <= HALT;
            halted_q   <= 1'b1;
            instr_id_q <= NOP_INSTR;
            valid_id_q <= 1'b0;
          end else begin
            pc_id_q    <= pc_if;
            instr_id_q <= imem_data;
            valid_id_q <= 1'b1;
            pc_q       <= pc_inc_d;
          end
        end
        HALT: begin
          if (branch_taken) begin
            state_q    <= RUN;
            halted_q   <= 1'b0;
            pc_q       <= branch_target[31:2];
            instr_id_q <= NOP_INSTR;
            valid_id_q <= 1'b0;
            misalign_q <= |branch_target[1:0];
          end else begin
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          halted_q   <= 1'b0;
          instr_id_q <= NOP_INSTR;
          valid_id_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; the ROM model returns word k = k.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_n, ENABLE, stall, flush, branch_taken;
  logic [31:0] branch_target;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_if, pc_id, instr_id;
  logic        valid_id, halted, misalign_err;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 CLK = ~CLK;

  assign imem_data = {22'd0, imem_addr};

  instr_fetch_unit dut (
    .CLK(CLK), .RST_n(RST_n), .ENABLE(ENABLE), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .pc_if(pc_if), .pc_id(pc_id), .instr_id(instr_id), .valid_id(valid_id),
    .halted(halted), .misalign_err(misalign_err)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_n = 1'b0; ENABLE = 1'b0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    tick(); tick();
    n_checks++; if (pc_if !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp %h", pc_if, 32'h0); end
    n_checks++; if (pc_id !== 32'h0) begin n_fail++; $display("FAIL rst_pc_id: got %h exp %h", pc_id, 32'h0); end
    n_checks++; if (instr_id !== 32'h13) begin n_fail++; $display("FAIL rst_instr: got %h exp %h", instr_id, 32'h13); end
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", valid_id); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b exp 0", halted); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b exp 0", misalign_err); end
  endtask

  task automatic test_run();
    RST_n = 1'b1; ENABLE = 1'b1;
    tick();
    n_checks++; if (pc_if !== 32'h0) begin n_fail++; $display("FAIL idle_pc: got %h exp %h", pc_if, 32'h0); end
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b exp 0", valid_id); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (pc_id !== 32'(4 * k)) begin n_fail++; $display("FAIL run_pc_id[%0d]: got %h exp %h", k, pc_id, 4 * k); end
      n_checks++; if (instr_id !== 32'(k)) begin n_fail++; $display("FAIL run_instr[%0d]: got %h exp %h", k, instr_id, k); end
      n_checks++; if (valid_id !== 1'b1) begin n_fail++; $display("FAIL run_valid[%0d]: got %b exp 1", k, valid_id); end
      n_checks++; if (imem_addr !== 10'(k + 1)) begin n_fail++; $display("FAIL run_addr[%0d]: got %h exp %h", k, imem_addr, k + 1); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc_if !== 32'h10) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h exp %h", i, pc_if, 32'h10); end
      n_checks++; if (instr_id !== 32'd3) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h exp %h", i, instr_id, 3); end
    end
    stall = 1'b0;
    tick();
    n_checks++; if (instr_id !== 32'd4) begin n_fail++; $display("FAIL unstall_instr: got %h exp %h", instr_id, 4); end
    n_checks++; if (pc_id !== 32'h10) begin n_fail++; $display("FAIL unstall_pc_id: got %h exp %h", pc_id, 32'h10); end
    n_checks++; if (pc_if !== 32'h14) begin n_fail++; $display("FAIL unstall_pc: got %h exp %h", pc_if, 32'h14); end
  endtask

  task automatic test_branch_stall();
    branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h40;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    n_checks++; if (pc_if !== 32'h40) begin n_fail++; $display("FAIL br_pc: got %h exp %h", pc_if, 32'h40); end
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b exp 0", valid_id); end
    n_checks++; if (instr_id !== 32'h13) begin n_fail++; $display("FAIL br_instr: got %h exp %h", instr_id, 32'h13); end
    n_checks++; if (pc_id !== 32'h10) begin n_fail++; $display("FAIL br_pc_id_hold: got %h exp %h", pc_id, 32'h10); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL br_misalign: got %b exp 0", misalign_err); end
    tick();
    n_checks++; if (instr_id !== 32'd16) begin n_fail++; $display("FAIL br_next_instr: got %h exp %h", instr_id, 16); end
    n_checks++; if (pc_id !== 32'h40) begin n_fail++; $display("FAIL br_next_pc_id: got %h exp %h", pc_id, 32'h40); end
  endtask

  task automatic test_misalign();
    branch_taken = 1'b1; branch_target = 32'h46;
    tick();
    branch_taken = 1'b0;
    n_checks++; if (pc_if !== 32'h44) begin n_fail++; $display("FAIL mis_pc: got %h exp %h", pc_if, 32'h44); end
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b exp 1", misalign_err); end
    tick();
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b exp 0", misalign_err); end
    n_checks++; if (instr_id !== 32'd17) begin n_fail++; $display("FAIL mis_instr: got %h exp %h", instr_id, 17); end
  endtask

  task automatic test_flush_enable();
    flush = 1'b1;
    tick();
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", valid_id); end
    n_checks++; if (pc_if !== 32'h4C) begin n_fail++; $display("FAIL flush_pc: got %h exp %h", pc_if, 32'h4C); end
    n_checks++; if (pc_id !== 32'h44) begin n_fail++; $display("FAIL flush_pc_id: got %h exp %h", pc_id, 32'h44); end
    stall = 1'b1;
    tick();
    n_checks++; if (pc_if !== 32'h4C) begin n_fail++; $display("FAIL flush_stall_pc: got %h exp %h", pc_if, 32'h4C); end
    flush = 1'b0; stall = 1'b0; ENABLE = 1'b0;
    tick();
    n_checks++; if (pc_if !== 32'h4C) begin n_fail++; $display("FAIL disable_pc: got %h exp %h", pc_if, 32'h4C); end
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL disable_valid: got %b exp 0", valid_id); end
    ENABLE = 1'b1;
    tick();
    n_checks++; if (instr_id !== 32'd19) begin n_fail++; $display("FAIL reenable_instr: got %h exp %h", instr_id, 19); end
  endtask

  task automatic test_out_of_range();
    branch_taken = 1'b1; branch_target = 32'hFFC;
    tick();
    branch_taken = 1'b0;
    n_checks++; if (pc_if !== 32'hFFC) begin n_fail++; $display("FAIL oor_redirect: got %h exp %h", pc_if, 32'hFFC); end
    tick();
    n_checks++; if (instr_id !== 32'h3FF) begin n_fail++; $display("FAIL oor_last_word: got %h exp %h", instr_id, 32'h3FF); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL oor_last_halted: got %b exp 0", halted); end
    tick();
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL oor_halted: got %b exp 1", halted); end
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL oor_valid: got %b exp 0", valid_id); end
    n_checks++; if (pc_if !== 32'h1000) begin n_fail++; $display("FAIL oor_pc: got %h exp %h", pc_if, 32'h1000); end
    stall = 1'b1; flush = 1'b1; ENABLE = 1'b0;
    tick();
    stall = 1'b0; flush = 1'b0; ENABLE = 1'b1;
    tick();
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %b exp 1", halted); end
    n_checks++; if (pc_if !== 32'h1000) begin n_fail++; $display("FAIL halt_pc_hold: got %h exp %h", pc_if, 32'h1000); end
    branch_taken = 1'b1; branch_target = 32'h0;
    tick();
    branch_taken = 1'b0;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_exit: got %b exp 0", halted); end
    n_checks++; if (pc_if !== 32'h0) begin n_fail++; $display("FAIL halt_exit_pc: got %h exp %h", pc_if, 32'h0); end
    tick();
    n_checks++; if (valid_id !== 1'b1) begin n_fail++; $display("FAIL resume_valid: got %b exp 1", valid_id); end
    n_checks++; if (pc_if !== 32'h4) begin n_fail++; $display("FAIL resume_pc: got %h exp %h", pc_if, 32'h4); end
  endtask

  task automatic test_reset_mid_run();
    branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    tick();
    n_checks++; if (pc_id !== 32'h80) begin n_fail++; $display("FAIL pre_rst_pc_id: got %h exp %h", pc_id, 32'h80); end
    stall = 1'b1; RST_n = 1'b0;
    tick();
    n_checks++; if (pc_if !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pc: got %h exp %h", pc_if, 32'h0); end
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b exp 0", valid_id); end
    n_checks++; if (pc_id !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pc_id: got %h exp %h", pc_id, 32'h0); end
    stall = 1'b0; RST_n = 1'b1;
    tick();
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL mid_rst_idle: got %b exp 0", valid_id); end
    n_checks++; if (pc_if !== 32'h0) begin n_fail++; $display("FAIL mid_rst_idle_pc: got %h exp %h", pc_if, 32'h0); end
    tick();
    n_checks++; if (valid_id !== 1'b1) begin n_fail++; $display("FAIL mid_rst_run: got %b exp 1", valid_id); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_branch_stall();
    test_misalign();
    test_flush_enable();
    test_out_of_range();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the single-issue 32-bit core.
- Holds the program counter and drives the word address of the asynchronous instruction ROM (1024 x 32, combinational read).
- Captures the returned instruction into the IF/ID pipeline register consumed by decode.
- Handles start-up, stall, flush, branch redirect and out-of-range halt.

Parameters:
ADDR_WIDTH, 10, ROM word-address width (ROM depth = 2**ADDR_WIDTH words)
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST_n  input  1  synchronous reset, active low
ENABLE  input  1  run enable; 0 in RUN acts as stall
stall  input  1  hazard stall from decode/execute: hold PC and IF/ID
flush  input  1  squash IF/ID contents (insert bubble)
branch_taken  input  1  redirect request from execute
branch_target  input  32  redirect byte address
imem_addr  output  ADDR_WIDTH  word address to ROM = pc[ADDR_WIDTH+1:2]
imem_data  input  DATA_WIDTH  ROM read data, valid same cycle as imem_addr
pc_if  output  32  current fetch PC
pc_id  output  32  PC of instruction in IF/ID
instr_id  output  DATA_WIDTH  instruction in IF/ID
valid_id  output  1  IF/ID holds a real instruction
halted  output  1  high in HALT state
misalign_err  output  1  one-cycle pulse: redirect target had bits[1:0]!=0

Behaviour:
- Reset is synchronous and active-low on RST_n. While RST_n=0 at a CLK edge:
  - state=IDLE, pc=RESET_PC, pc_id=0, instr_id=NOP_INSTR.
  - valid_id=0, halted=0, misalign_err=0.
- imem_addr is combinational from pc. The ROM is asynchronous, so the fetch-to-IF/ID latency is one cycle.
- States IDLE, RUN, HALT (2-bit encoding):
  - IDLE: pc held, IF/ID is a bubble. ENABLE=1 -> RUN next edge; nothing is latched on that edge.
  - RUN, priority order per edge:
    1. branch_taken: pc<=branch_target & ~3; IF/ID<=bubble (valid_id=0, instr_id=NOP_INSTR, pc_id unchanged); misalign_err<=|branch_target[1:0].
    2. flush: IF/ID<=bubble. pc advances by 4 unless stall or ENABLE=0.
    3. stall or ENABLE=0: pc, pc_id, instr_id, valid_id all held.
    4. Otherwise, out-of-range fetch (pc[31:ADDR_WIDTH+2]!=0): state<=HALT, IF/ID<=bubble, pc held.
    5. Otherwise, normal: pc_id<=pc, instr_id<=imem_data, valid_id<=1, pc<=pc+4.
  - HALT: halted=1, IF/ID bubble, pc held, stall and flush ignored.
    - branch_taken -> RUN with redirect as in rule 1; halted drops on that edge.
    - ENABLE ignored.
- misalign_err is 0 on every edge without branch_taken.
- Branch takes priority over stall on the same edge: the stalled instruction is discarded.
- pc+4 wraps modulo 2**32. The in-range check catches fetches past the ROM end before any wrap.
- Last ROM word (pc = 4*(2**ADDR_WIDTH-1)) fetches normally. The following edge enters HALT.
- Reset mid-operation takes effect on the next edge regardless of state or other inputs.

Test Plan:
1. Reset + run: RST_n=0 two cycles, then RST_n=1, ENABLE=1, ROM word k = k.
   -> IDLE one edge; then pc_id/instr_id = 0/0, 4/1, 8/2 on consecutive edges with valid_id=1; imem_addr tracks pc>>2.
2. Stall: assert stall for 3 cycles at pc=0x10.
   -> pc_if stays 0x10 and instr_id stays 3 throughout. On release, instr_id=4, pc_id=0x10.
3. Branch with simultaneous stall: branch_taken=1, stall=1, branch_target=0x40.
   -> next edge pc_if=0x40, valid_id=0, instr_id=0x13. Following edge instr_id=16, pc_id=0x40.
4. Misaligned redirect: branch_target=0x46.
   -> pc_if=0x44, misalign_err=1 for exactly one cycle.
5. Out of range: redirect to 0xFFC and run.
   -> instr_id=word 1023. Next edge halted=1, valid_id=0, pc_if=0x1000 held. Then branch_taken to 0x0 -> halted=0, normal fetch resumes.
6. Reset mid-run: RST_n=0 at pc=0x80 with stall=1.
   -> next edge pc_if=0, valid_id=0, state IDLE.
